// File: rtl/dc_blocker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dc_blocker_pkg                                               |
// | Description : Shared types and helpers for the multi-channel DC blocker:   |
// |               FSM state encoding, signed saturation, and a constant-time   |
// |               helper that turns a real alpha into its fixed-point code.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dc_blocker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      UPDATE = 2'd2
   } states_t;

   // Clamp a signed value into the two's complement range of 'width' bits.
   // Width is always a constant at the call site, so the bounds fold away.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int                 width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

   // Alpha code for an unsigned Q0.(internal_dw-1) coefficient, rounded to
   // nearest. Intended for elaboration-time use by instantiating levels.
   function automatic logic [63:0] alpha_from_real(input real a, input int internal_dw);
      real scaled;
      scaled = a * (2.0 ** (internal_dw - 1)) + 0.5;
      return 64'($rtoi(scaled));
   endfunction

endpackage
`default_nettype wire

// File: rtl/dc_blocker_state_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dc_blocker_state_ram                                         |
// | Description : Per-channel x[n-1] / y[n-1] register file. One asynchronous |
// |               read port, one write port, synchronous clear of all entries. |
// | Ports       : clk, rst      - clock, async active-high reset               |
// |               clear_i       - zero every entry at the next edge (wins      |
// |                               over a write in the same cycle)              |
// |               rd_ch_i       - read channel; rd_x_o / rd_y_o combinational  |
// |               wr_en_i, wr_ch_i, wr_x_i, wr_y_i - write port                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dc_blocker_state_ram #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int DW     = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic [CH_W-1:0]      rd_ch_i,
   output logic signed [DW-1:0] rd_x_o,
   output logic signed [DW-1:0] rd_y_o,
   input  logic                 wr_en_i,
   input  logic [CH_W-1:0]      wr_ch_i,
   input  logic signed [DW-1:0] wr_x_i,
   input  logic signed [DW-1:0] wr_y_i
);

   logic signed [DW-1:0] x_prev_q [NUM_CH];
   logic signed [DW-1:0] x_prev_d [NUM_CH];
   logic signed [DW-1:0] y_prev_q [NUM_CH];
   logic signed [DW-1:0] y_prev_d [NUM_CH];

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         x_prev_d[i] = x_prev_q[i];
         y_prev_d[i] = y_prev_q[i];
         if (clear_i) begin
            x_prev_d[i] = '0;
            y_prev_d[i] = '0;
         end else if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
            x_prev_d[i] = wr_x_i;
            y_prev_d[i] = wr_y_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            x_prev_q[i] <= '0;
            y_prev_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            x_prev_q[i] <= x_prev_d[i];
            y_prev_q[i] <= y_prev_d[i];
         end
      end
   end

   // Unpopulated tag codes (NUM_CH not a power of two) read as zero.
   always_comb begin
      rd_x_o = '0;
      rd_y_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch_i == CH_W'(i)) begin
            rd_x_o = x_prev_q[i];
            rd_y_o = y_prev_q[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dc_blocker_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dc_blocker_mc                                                |
// | Description : Time-multiplexed DC blocking filter                          |
// |               y[n] = x[n] - x[n-1] + alpha*y[n-1], one datapath shared by  |
// |               NUM_CH channels. One sample in flight, 3 cycles per sample,  |
// |               valid_o two cycles after the accepting edge.                 |
// | Ports       : clk, rst         - clock, async active-high reset            |
// |               data_i, ch_i, valid_i, ready_o, en_i - sample input          |
// |               bypass_i, alpha_i - per-sample controls, sampled at accept   |
// |               clear_i          - zero all channel state, abort in-flight   |
// |               valid_o, ch_o, data_o - output strobe, tag, signed sample    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dc_blocker_mc
   import dc_blocker_pkg::*;
#(
   parameter int  INPUT_DW           = 12,
   parameter int  INTERNAL_FRAC_BITS = 8,
   parameter int  OUTPUT_FRAC_BITS   = 4,
   parameter int  NUM_CH             = 4,
   parameter int  INPUT_SIGNED       = 0,
   localparam int INTERNAL_DW        = INPUT_DW + INTERNAL_FRAC_BITS + 1,
   localparam int OUTPUT_DW          = INPUT_DW + OUTPUT_FRAC_BITS + 1,
   localparam int CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INPUT_DW-1:0]         data_i,
   input  logic [CH_W-1:0]             ch_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic                        en_i,
   input  logic                        bypass_i,
   input  logic                        clear_i,
   input  logic [INTERNAL_DW-1:0]      alpha_i,
   output logic                        valid_o,
   output logic [CH_W-1:0]             ch_o,
   output logic signed [OUTPUT_DW-1:0] data_o
);

   localparam int OUT_SHIFT = INTERNAL_FRAC_BITS - OUTPUT_FRAC_BITS;
   // p and the pre-saturation sum carry two guard bits: alpha may approach 2.0,
   // so |p| can reach twice the state magnitude.
   localparam int P_W       = INTERNAL_DW + 2;
   localparam int SUM_W     = INTERNAL_DW + 2;
   localparam int PROD_W    = 2 * INTERNAL_DW + 1;
   localparam logic [CH_W:0] NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

   states_t                       state_q, state_d;
   logic signed [INTERNAL_DW-1:0] x_q, x_d;
   logic [CH_W-1:0]               ch_q, ch_d;
   logic                          byp_q, byp_d;
   logic [INTERNAL_DW-1:0]        alpha_q, alpha_d;
   logic signed [P_W-1:0]         p_q, p_d;
   logic                          valid_o_q, valid_o_d;
   logic signed [OUTPUT_DW-1:0]   data_o_q, data_o_d;
   logic [CH_W-1:0]               ch_o_q, ch_o_d;

   logic                          sign_bit;
   logic signed [INTERNAL_DW-1:0] x_ext;
   logic                          ch_in_range;
   logic                          accept;
   logic signed [INTERNAL_DW-1:0] rd_x;
   logic signed [INTERNAL_DW-1:0] rd_y;
   logic signed [PROD_W-1:0]      prod;
   logic signed [SUM_W-1:0]       sum;
   logic signed [INTERNAL_DW-1:0] y_sat;
   logic signed [OUTPUT_DW-1:0]   y_out;
   logic signed [OUTPUT_DW-1:0]   x_out;
   logic                          wr_en;

   // Input lands with INTERNAL_FRAC_BITS of fraction and one sign bit on top;
   // unsigned samples get a zero sign so they stay non-negative.
   assign sign_bit    = (INPUT_SIGNED != 0) ? data_i[INPUT_DW-1] : 1'b0;
   assign x_ext       = INTERNAL_DW'($signed({sign_bit, data_i})) <<< INTERNAL_FRAC_BITS;
   assign ch_in_range = ({1'b0, ch_i} < NUM_CH_EXT);

   assign ready_o = (state_q == IDLE) && !clear_i;
   assign accept  = valid_i && en_i && ready_o;

   // alpha is unsigned, so a zero MSB is prepended before the signed multiply.
   assign prod  = PROD_W'(rd_y) * PROD_W'($signed({1'b0, alpha_q}));
   assign sum   = SUM_W'(x_q) - SUM_W'(rd_x) + SUM_W'(p_q);
   assign y_sat = INTERNAL_DW'(sat_signed(64'(sum), INTERNAL_DW));
   assign y_out = OUTPUT_DW'(y_sat >>> OUT_SHIFT);
   assign x_out = OUTPUT_DW'(x_q >>> OUT_SHIFT);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      ch_d      = ch_q;
      byp_d     = byp_q;
      alpha_d   = alpha_q;
      p_d       = p_q;
      valid_o_d = 1'b0;
      data_o_d  = data_o_q;
      ch_o_d    = ch_o_q;
      wr_en     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               x_d     = x_ext;
               ch_d    = ch_i;
               // A tag with no backing state is forced through the bypass path.
               byp_d   = bypass_i || !ch_in_range;
               alpha_d = alpha_i;
               state_d = MULT;
            end
         end
         MULT: begin
            p_d     = P_W'(prod >>> (INTERNAL_DW - 1));
            state_d = UPDATE;
         end
         UPDATE: begin
            wr_en     = !byp_q;
            data_o_d  = byp_q ? x_out : y_out;
            ch_o_d    = ch_q;
            valid_o_d = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear aborts the in-flight sample; the output registers keep their
      // last published value.
      if (clear_i) begin
         state_d   = IDLE;
         valid_o_d = 1'b0;
         wr_en     = 1'b0;
         data_o_d  = data_o_q;
         ch_o_d    = ch_o_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         x_q       <= '0;
         ch_q      <= '0;
         byp_q     <= 1'b0;
         alpha_q   <= '0;
         p_q       <= '0;
         valid_o_q <= 1'b0;
         data_o_q  <= '0;
         ch_o_q    <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         ch_q      <= ch_d;
         byp_q     <= byp_d;
         alpha_q   <= alpha_d;
         p_q       <= p_d;
         valid_o_q <= valid_o_d;
         data_o_q  <= data_o_d;
         ch_o_q    <= ch_o_d;
      end
   end

   assign valid_o = valid_o_q;
   assign data_o  = data_o_q;
   assign ch_o    = ch_o_q;

   dc_blocker_state_ram #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .DW     (INTERNAL_DW)
   ) u_state_ram (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .rd_ch_i (ch_q),
      .rd_x_o  (rd_x),
      .rd_y_o  (rd_y),
      .wr_en_i (wr_en),
      .wr_ch_i (ch_q),
      .wr_x_i  (x_q),
      .wr_y_i  (y_sat)
   );

endmodule
`default_nettype wire
